// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and field layout for the streaming register-machine core
package cpu_pkg;

  localparam int NREGS = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_ADDI = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_SHL  = 4'h9,
    OP_SHR  = 4'hA,
    OP_OUT  = 4'hB,
    OP_HALT = 4'hF
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_t;

  // Instruction word: {op[3:0], rd[1:0], rs[1:0], imm[DATA_WIDTH-1:0]}
  function automatic int instr_width(input int dw);
    return dw + 8;
  endfunction

  function automatic int op_lsb(input int dw);
    return dw + 4;
  endfunction

  function automatic int rd_lsb(input int dw);
    return dw + 2;
  endfunction

  function automatic int rs_lsb(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/cpu_core_if.sv
// rtl/cpu_core_if.sv - loader, control and output signals of the core
interface cpu_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    instr_valid;
  logic                    instr_ready;
  logic [DATA_WIDTH+7:0]   instr_data;
  logic                    resume;
  logic                    busy;
  logic                    halted;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    zero;
  logic                    carry;

  modport master (
    output instr_valid, instr_data, resume,
    input  instr_ready, busy, halted, out_valid, out_data, zero, carry
  );

  modport slave (
    input  instr_valid, instr_data, resume,
    output instr_ready, busy, halted, out_valid, out_data, zero, carry
  );
endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - instruction queue with registered (synchronous) read port
module instr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rd_data <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - queued fetch/execute register-machine core with flags and output port
module cpu_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic       clk,
  input  logic       reset,
  cpu_core_if.slave  bus
);
  import cpu_pkg::*;

  localparam int IW     = instr_width(DATA_WIDTH);
  localparam int OP_LO  = op_lsb(DATA_WIDTH);
  localparam int RD_LO  = rd_lsb(DATA_WIDTH);
  localparam int RS_LO  = rs_lsb(DATA_WIDTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  state_t                 state_q;
  state_t                 state_d;
  logic                   fifo_pop;
  logic                   load_ir;
  logic                   exec_en;
  logic [IW-1:0]          fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   unused_fifo_count;

  logic [IW-1:0]          ir_q;
  op_t                    ir_op;
  logic [1:0]             rd_idx;
  logic [1:0]             rs_idx;
  logic [DATA_WIDTH-1:0]  imm;
  logic [DATA_WIDTH-1:0]  rd_val;
  logic [DATA_WIDTH-1:0]  rs_val;
  logic [DATA_WIDTH-1:0]  regs_q [NREGS];

  logic [DATA_WIDTH:0]    wide;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_carry;
  logic                   wr_reg;
  logic                   upd_zero;
  logic                   upd_carry;

  logic                   zero_q;
  logic                   carry_q;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;

  instr_fifo #(
    .WIDTH (IW),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.instr_valid),
    .wr_data (bus.instr_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  assign ir_op  = op_t'(ir_q[OP_LO +: 4]);
  assign rd_idx = ir_q[RD_LO +: 2];
  assign rs_idx = ir_q[RS_LO +: 2];
  assign imm    = ir_q[DATA_WIDTH-1:0];
  assign rd_val = regs_q[rd_idx];
  assign rs_val = regs_q[rs_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // HALT is decided from the opcode alone, so a resume seen during EXEC is ignored.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load_ir  = 1'b0;
    exec_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        load_ir = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        exec_en = 1'b1;
        state_d = (ir_op == OP_HALT) ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        if (bus.resume) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wide      = '0;
    alu_res   = rd_val;
    alu_carry = carry_q;
    wr_reg    = 1'b0;
    upd_zero  = 1'b0;
    upd_carry = 1'b0;
    case (ir_op)
      OP_LDI: begin
        alu_res  = imm;
        wr_reg   = 1'b1;
        upd_zero = 1'b1;
      end
      OP_MOV: begin
        alu_res  = rs_val;
        wr_reg   = 1'b1;
        upd_zero = 1'b1;
      end
      OP_ADD, OP_ADDI: begin
        wide      = {1'b0, rd_val} + {1'b0, (ir_op == OP_ADD) ? rs_val : imm};
        alu_res   = wide[DATA_WIDTH-1:0];
        alu_carry = wide[DATA_WIDTH];
        wr_reg    = 1'b1;
        upd_zero  = 1'b1;
        upd_carry = 1'b1;
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        wide      = {1'b0, rd_val} - {1'b0, rs_val};
        alu_res   = wide[DATA_WIDTH-1:0];
        alu_carry = wide[DATA_WIDTH];
        wr_reg    = 1'b1;
        upd_zero  = 1'b1;
        upd_carry = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR: begin
        alu_res  = (ir_op == OP_AND) ? (rd_val & rs_val) :
                   (ir_op == OP_OR)  ? (rd_val | rs_val) : (rd_val ^ rs_val);
        wr_reg   = 1'b1;
        upd_zero = 1'b1;
      end
      OP_SHL: begin
        alu_res   = {rd_val[DATA_WIDTH-2:0], 1'b0};
        alu_carry = rd_val[DATA_WIDTH-1];
        wr_reg    = 1'b1;
        upd_zero  = 1'b1;
        upd_carry = 1'b1;
      end
      OP_SHR: begin
        alu_res   = {1'b0, rd_val[DATA_WIDTH-1:1]};
        alu_carry = rd_val[0];
        wr_reg    = 1'b1;
        upd_zero  = 1'b1;
        upd_carry = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (exec_en && wr_reg) begin
      regs_q[rd_idx] <= alu_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q        <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= exec_en && (ir_op == OP_OUT);
      if (load_ir) begin
        ir_q <= fifo_rd_data;
      end
      if (exec_en && upd_zero) begin
        zero_q <= (alu_res == '0);
      end
      if (exec_en && upd_carry) begin
        carry_q <= alu_carry;
      end
      if (exec_en && (ir_op == OP_OUT)) begin
        out_data_q <= rs_val;
      end
    end
  end

  assign bus.instr_ready = !fifo_full;
  assign bus.busy        = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.zero        = zero_q;
  assign bus.carry       = carry_q;

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - directed-vector bench for cpu_core
module tb_cpu_core;

  localparam logic [3:0] LDI = 4'h1, MOV = 4'h2, ADD = 4'h3, ADDI = 4'h4, SUB = 4'h5;
  localparam logic [3:0] AND_ = 4'h6, OR_ = 4'h7, XOR_ = 4'h8, SHL = 4'h9, SHR = 4'hA;
  localparam logic [3:0] OUT = 4'hB, HLT = 4'hF;

  logic       clk = 1'b0;
  logic       reset;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] out_q[$];

  cpu_core_if #(.DATA_WIDTH(8)) bus();

  cpu_core #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) out_q.push_back(bus.out_data);
  end

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic put(input logic [15:0] w);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = w;
  endtask

  task automatic release_bus();
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_resume();
    @(negedge clk);
    bus.resume = 1'b1;
    @(negedge clk);
    bus.resume = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    bus.resume      = 1'b0;
    cycles(2);
    vectors++; if (bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    vectors++; if ({bus.zero, bus.carry} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {bus.zero, bus.carry}); end
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_add();
    out_q.delete();
    put(mk(LDI, 2'd0, 2'd0, 8'hF0));
    put(mk(LDI, 2'd1, 2'd0, 8'h20));
    put(mk(ADD, 2'd0, 2'd1, 8'h00));
    put(mk(OUT, 2'd0, 2'd0, 8'h00));
    release_bus();
    cycles(14);
    vectors++; if (out_q.size() != 1) begin miscompares++; $display("FAIL add_pulses: got %0d want 1", out_q.size()); end
    vectors++; if (bus.out_data !== 8'h10) begin miscompares++; $display("FAIL add_out_data: got %h want 10", bus.out_data); end
    vectors++; if ({bus.zero, bus.carry} !== 2'b01) begin miscompares++; $display("FAIL add_flags zc: got %b want 01", {bus.zero, bus.carry}); end
  endtask

  task automatic test_sub();
    out_q.delete();
    put(mk(LDI, 2'd2, 2'd0, 8'h05));
    put(mk(SUB, 2'd2, 2'd2, 8'h00));
    put(mk(OUT, 2'd0, 2'd2, 8'h00));
    release_bus();
    cycles(12);
    vectors++; if (out_q.size() != 1 || bus.out_data !== 8'h00) begin miscompares++; $display("FAIL sub_self: got n=%0d data=%h want n=1 data=00", out_q.size(), bus.out_data); end
    vectors++; if ({bus.zero, bus.carry} !== 2'b10) begin miscompares++; $display("FAIL sub_self_flags zc: got %b want 10", {bus.zero, bus.carry}); end
    put(mk(LDI, 2'd2, 2'd0, 8'h01));
    put(mk(LDI, 2'd3, 2'd0, 8'h02));
    put(mk(SUB, 2'd2, 2'd3, 8'h00));
    put(mk(OUT, 2'd0, 2'd2, 8'h00));
    release_bus();
    cycles(14);
    vectors++; if (bus.out_data !== 8'hFF) begin miscompares++; $display("FAIL sub_borrow_data: got %h want ff", bus.out_data); end
    vectors++; if ({bus.zero, bus.carry} !== 2'b01) begin miscompares++; $display("FAIL sub_borrow_flags zc: got %b want 01", {bus.zero, bus.carry}); end
  endtask

  task automatic test_latency();
    put(mk(OUT, 2'd0, 2'd0, 8'h00));
    release_bus();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL lat_no_same_cycle_pop: got busy=%b want 0", bus.busy); end
    cycles(1);
    vectors++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_fetch: got busy=%b ov=%b want 1 0", bus.busy, bus.out_valid); end
    cycles(1);
    vectors++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_exec: got busy=%b ov=%b want 1 0", bus.busy, bus.out_valid); end
    cycles(1);
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10) begin miscompares++; $display("FAIL lat_out: got ov=%b data=%h want 1 10", bus.out_valid, bus.out_data); end
    cycles(1);
    vectors++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h10) begin miscompares++; $display("FAIL lat_pulse_end: got ov=%b data=%h want 0 10", bus.out_valid, bus.out_data); end
    cycles(3);
  endtask

  task automatic test_logic();
    logic [7:0] exp_out [4] = '{8'h02, 8'h01, 8'h00, 8'h0F};
    out_q.delete();
    put(mk(LDI,  2'd0, 2'd0, 8'h81));
    put(mk(SHL,  2'd0, 2'd0, 8'h00));
    put(mk(OUT,  2'd0, 2'd0, 8'h00));
    put(mk(SHR,  2'd0, 2'd0, 8'h00));
    put(mk(OUT,  2'd0, 2'd0, 8'h00));
    put(mk(SHR,  2'd0, 2'd0, 8'h00));
    put(mk(OUT,  2'd0, 2'd0, 8'h00));
    put(mk(LDI,  2'd1, 2'd0, 8'h0F));
    put(mk(XOR_, 2'd0, 2'd1, 8'h00));
    put(mk(LDI,  2'd2, 2'd0, 8'hF0));
    put(mk(OR_,  2'd0, 2'd2, 8'h00));
    put(mk(AND_, 2'd0, 2'd1, 8'h00));
    put(mk(MOV,  2'd3, 2'd0, 8'h00));
    put(mk(OUT,  2'd0, 2'd3, 8'h00));
    put(mk(ADDI, 2'd3, 2'd0, 8'hF1));
    release_bus();
    cycles(50);
    vectors++; if (out_q.size() != 4) begin miscompares++; $display("FAIL logic_pulses: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= out_q.size() || out_q[i] !== exp_out[i]) begin
        miscompares++; $display("FAIL logic_out[%0d]: got %h (n=%0d) want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, out_q.size(), exp_out[i]);
      end
    end
    vectors++; if ({bus.zero, bus.carry} !== 2'b11) begin miscompares++; $display("FAIL addi_wrap_flags zc: got %b want 11", {bus.zero, bus.carry}); end
  endtask

  task automatic test_nop_code();
    out_q.delete();
    put(mk(LDI,  2'd1, 2'd0, 8'hFF));
    put(mk(ADDI, 2'd1, 2'd0, 8'h02));
    put(mk(4'hC, 2'd1, 2'd1, 8'h00));
    release_bus();
    cycles(12);
    vectors++; if (bus.busy !== 1'b0 || bus.halted !== 1'b0) begin miscompares++; $display("FAIL opc_idle: got busy=%b halted=%b want 0 0", bus.busy, bus.halted); end
    vectors++; if ({bus.zero, bus.carry} !== 2'b01) begin miscompares++; $display("FAIL opc_flags zc: got %b want 01", {bus.zero, bus.carry}); end
    put(mk(OUT, 2'd0, 2'd1, 8'h00));
    release_bus();
    cycles(6);
    vectors++; if (out_q.size() != 1 || bus.out_data !== 8'h01) begin miscompares++; $display("FAIL opc_r1: got n=%0d data=%h want n=1 data=01", out_q.size(), bus.out_data); end
  endtask

  task automatic test_fill();
    put(mk(HLT, 2'd0, 2'd0, 8'h00));
    release_bus();
    cycles(5);
    vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL fill_halted: got %b want 1", bus.halted); end
    out_q.delete();
    for (int k = 1; k <= 8; k++) begin
      put(mk(LDI, 2'd0, 2'd0, 8'(k * 8'h11)));
      if (k == 8) begin
        vectors++; if (bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_15: got %b want 1", bus.instr_ready); end
      end
      put(mk(OUT, 2'd0, 2'd0, 8'h00));
    end
    put(mk(OUT, 2'd0, 2'd1, 8'h00));
    vectors++; if (bus.instr_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_16: got %b want 0", bus.instr_ready); end
    release_bus();
    vectors++; if (bus.instr_ready !== 1'b0 || bus.halted !== 1'b1) begin miscompares++; $display("FAIL fill_held: got ready=%b halted=%b want 0 1", bus.instr_ready, bus.halted); end
    pulse_resume();
    cycles(54);
    vectors++; if (out_q.size() != 8) begin miscompares++; $display("FAIL fill_pulses: got %0d want 8", out_q.size()); end
    for (int k = 1; k <= 8; k++) begin
      vectors++;
      if (k > out_q.size() || out_q[k-1] !== 8'(k * 8'h11)) begin
        miscompares++; $display("FAIL fill_order[%0d]: got %h want %h", k - 1, (k <= out_q.size()) ? out_q[k-1] : 8'hxx, 8'(k * 8'h11));
      end
    end
    vectors++; if (bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL fill_end: got busy=%b halted=%b ready=%b want 0 0 1", bus.busy, bus.halted, bus.instr_ready); end
  endtask

  task automatic test_halt_resume();
    out_q.delete();
    put(mk(HLT, 2'd0, 2'd0, 8'h00));
    put(mk(OUT, 2'd0, 2'd0, 8'h00));
    release_bus();
    cycles(10);
    vectors++; if (bus.halted !== 1'b1 || out_q.size() != 0) begin miscompares++; $display("FAIL halt_hold: got halted=%b pulses=%0d want 1 0", bus.halted, out_q.size()); end
    pulse_resume();
    vectors++; if (bus.halted !== 1'b0 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL resume_r0: got halted=%b ov=%b want 0 0", bus.halted, bus.out_valid); end
    cycles(2);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL resume_r2: got ov=%b want 0", bus.out_valid); end
    cycles(1);
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h88) begin miscompares++; $display("FAIL resume_r3: got ov=%b data=%h want 1 88", bus.out_valid, bus.out_data); end
    cycles(3);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(HLT, 2'd0, 2'd0, 8'h00);
    bus.resume      = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    cycles(3);
    bus.resume = 1'b0;
    vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL halt_over_resume: got %b want 1", bus.halted); end
    cycles(2);
    vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL halt_stays: got %b want 1", bus.halted); end
    pulse_resume();
    cycles(1);
    vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL halt_release: got %b want 0", bus.halted); end
  endtask

  task automatic test_reset_mid();
    put(mk(HLT, 2'd0, 2'd0, 8'h00));
    release_bus();
    cycles(5);
    put(mk(ADD, 2'd0, 2'd1, 8'h00));
    put(mk(OUT, 2'd0, 2'd0, 8'h00));
    put(mk(OUT, 2'd0, 2'd0, 8'h00));
    put(mk(OUT, 2'd0, 2'd0, 8'h00));
    release_bus();
    pulse_resume();
    cycles(2);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rmid_in_exec: got busy=%b want 1", bus.busy); end
    reset = 1'b1;
    #1;
    vectors++; if ({bus.out_valid, bus.out_data, bus.zero, bus.carry} !== 11'd0) begin miscompares++; $display("FAIL rmid_outputs: got ov=%b data=%h z=%b c=%b want all 0", bus.out_valid, bus.out_data, bus.zero, bus.carry); end
    vectors++; if (bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_state: got busy=%b halted=%b ready=%b want 0 0 1", bus.busy, bus.halted, bus.instr_ready); end
    @(negedge clk);
    reset = 1'b0;
    out_q.delete();
    cycles(20);
    vectors++; if (out_q.size() != 0 || bus.busy !== 1'b0 || bus.out_data !== 8'h00) begin miscompares++; $display("FAIL rmid_queue_flushed: got pulses=%0d busy=%b data=%h want 0 0 00", out_q.size(), bus.busy, bus.out_data); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_latency();
    test_logic();
    test_nop_code();
    test_fill();
    test_halt_resume();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
